// File: rtl/vdp_vram_pkg.sv
// rtl/vdp_vram_pkg.sv - shared types and constants for the VRAM access arbiter
// Purpose: owner tag enum carried through the read-return tag FIFO, slot width
//          and tag FIFO depth shared by the arbiter top and its sub-module.
// Ports:   none (package).
package vdp_vram_pkg;

  typedef enum logic [1:0] {
    OWNER_SCREEN  = 2'd0,
    OWNER_SPRITE  = 2'd1,
    OWNER_CPU     = 2'd2,
    OWNER_COMMAND = 2'd3
  } owner_t;

  // One grant opportunity every 2**SLOT_BITS clocks.
  localparam int SLOT_BITS      = 3;
  localparam int TAG_FIFO_DEPTH = 4;
  localparam int TAG_PTR_W      = $clog2(TAG_FIFO_DEPTH);

endpackage

// File: rtl/vdp_vram_access_arbiter_if.sv
// rtl/vdp_vram_access_arbiter_if.sv - VRAM-side bus between arbiter and memory
// Purpose: bundles the registered grant bus and the read-return path.
// Ports:   master = arbiter (drives address/valid/write/wdata, receives rdata/rdata_en)
//          slave  = memory controller (the reverse).
interface vdp_vram_access_arbiter_if;

  logic [16:0] vram_address;
  logic        vram_valid;
  logic        vram_write;
  logic [7:0]  vram_wdata;
  logic [31:0] vram_rdata;
  logic        vram_rdata_en;

  modport master (
    output vram_address, vram_valid, vram_write, vram_wdata,
    input  vram_rdata, vram_rdata_en
  );

  modport slave (
    input  vram_address, vram_valid, vram_write, vram_wdata,
    output vram_rdata, vram_rdata_en
  );

endinterface

// File: rtl/vdp_vram_tag_fifo.sv
// rtl/vdp_vram_tag_fifo.sv - in-order owner tag FIFO for outstanding VRAM reads
// Purpose: remembers who issued each granted read so returning data can be
//          steered to the right requester.
// Ports:   clk, reset_n (async active-low); push/push_tag enqueue; pop dequeues;
//          head_tag is the oldest tag; full/empty status.
//          Pop on empty is ignored; push on full is accepted only with a pop.
module vdp_vram_tag_fifo
  import vdp_vram_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   push,
  input  owner_t push_tag,
  input  logic   pop,
  output owner_t head_tag,
  output logic   full,
  output logic   empty
);

  logic [TAG_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [TAG_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [TAG_PTR_W:0]   count_q, count_d;
  owner_t               mem_q [TAG_FIFO_DEPTH];
  owner_t               mem_d [TAG_FIFO_DEPTH];
  logic                 do_push, do_pop;

  assign full     = (count_q == (TAG_PTR_W+1)'(TAG_FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_tag = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_tag;
      wr_ptr_d        = wr_ptr_q + TAG_PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + TAG_PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (TAG_PTR_W+1)'(1);
      2'b01:   count_d = count_q - (TAG_PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/vdp_vram_access_arbiter.sv
// rtl/vdp_vram_access_arbiter.sv - slot-based VRAM arbiter for screen, sprite, CPU and command
// Purpose: one grant per 8-clock slot at the slot boundary, priority
//          screen > sprite > cpu/command; grant registered one cycle later;
//          read data steered back through an in-order owner tag FIFO.
// Ports:   clk, reset_n (async active-low); screen_pos_x/screen_active slot timing;
//          screen_*/sprite_* fire-and-forget reads; cpu_*/command_* held requests
//          acknowledged by a one-cycle *_ready; *_rdata_en read-return strobes;
//          vram (master modport) grant bus and read return; rdata broadcast data.
// Option:  VDP_VRAM_ARB_ROUND_ROBIN_EN alternates cpu/command when both pending;
//          otherwise cpu has fixed priority over command.
module vdp_vram_access_arbiter
  import vdp_vram_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [12:0] screen_pos_x,
  input  logic        screen_active,
  input  logic [16:0] screen_address,
  input  logic        screen_valid,
  output logic        screen_rdata_en,
  input  logic [16:0] sprite_address,
  input  logic        sprite_valid,
  output logic        sprite_rdata_en,
  input  logic [16:0] cpu_address,
  input  logic        cpu_valid,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_rdata_en,
  input  logic [16:0] command_address,
  input  logic        command_valid,
  input  logic        command_write,
  input  logic [7:0]  command_wdata,
  output logic        command_ready,
  output logic        command_rdata_en,
  vdp_vram_access_arbiter_if.master vram,
  output logic [31:0] rdata
);

  logic        slot_boundary, fifo_full, fifo_empty, tag_pop, tag_push, cpu_first;
  owner_t      head_tag;
  logic        grant;
  owner_t      grant_owner;
  logic [16:0] grant_address;
  logic        grant_write;
  logic [7:0]  grant_wdata;

  logic        vram_valid_q, vram_valid_d;
  logic [16:0] vram_address_q, vram_address_d;
  logic        vram_write_q, vram_write_d;
  logic [7:0]  vram_wdata_q, vram_wdata_d;
  logic        cpu_ready_q, cpu_ready_d;
  logic        command_ready_q, command_ready_d;

  // Only the slot phase of the beam position matters here.
  logic        unused_pos_hi;
  assign unused_pos_hi = ^screen_pos_x[12:SLOT_BITS];

  assign slot_boundary = (screen_pos_x[SLOT_BITS-1:0] == '0);
  assign tag_pop       = vram.vram_rdata_en && !fifo_empty;

`ifdef VDP_VRAM_ARB_ROUND_ROBIN_EN
  // Set after a cpu grant so command wins the next tie, cleared after a command grant.
  logic rr_cmd_q, rr_cmd_d;

  always_comb begin
    rr_cmd_d = rr_cmd_q;
    if (grant && grant_owner == OWNER_CPU)     rr_cmd_d = 1'b1;
    if (grant && grant_owner == OWNER_COMMAND) rr_cmd_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rr_cmd_q <= 1'b0;
    else          rr_cmd_q <= rr_cmd_d;
  end

  assign cpu_first = !rr_cmd_q;
`else
  assign cpu_first = 1'b1;
`endif

  // A pop in the same cycle frees a FIFO entry, so a full FIFO can still grant.
  always_comb begin
    grant         = 1'b0;
    grant_owner   = OWNER_SCREEN;
    grant_address = '0;
    grant_write   = 1'b0;
    grant_wdata   = '0;
    if (slot_boundary && (!fifo_full || tag_pop)) begin
      if (screen_valid && screen_active) begin
        grant         = 1'b1;
        grant_owner   = OWNER_SCREEN;
        grant_address = screen_address;
      end else if (sprite_valid) begin
        grant         = 1'b1;
        grant_owner   = OWNER_SPRITE;
        grant_address = sprite_address;
      end else if (cpu_valid && (cpu_first || !command_valid)) begin
        grant         = 1'b1;
        grant_owner   = OWNER_CPU;
        grant_address = cpu_address;
        grant_write   = cpu_write;
        grant_wdata   = cpu_wdata;
      end else if (command_valid) begin
        grant         = 1'b1;
        grant_owner   = OWNER_COMMAND;
        grant_address = command_address;
        grant_write   = command_write;
        grant_wdata   = command_wdata;
      end
    end
  end

  assign tag_push = grant && !grant_write;

  always_comb begin
    vram_valid_d    = grant;
    vram_address_d  = grant_address;
    vram_write_d    = grant_write;
    vram_wdata_d    = grant_wdata;
    cpu_ready_d     = grant && (grant_owner == OWNER_CPU);
    command_ready_d = grant && (grant_owner == OWNER_COMMAND);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vram_valid_q    <= 1'b0;
      vram_address_q  <= '0;
      vram_write_q    <= 1'b0;
      vram_wdata_q    <= '0;
      cpu_ready_q     <= 1'b0;
      command_ready_q <= 1'b0;
    end else begin
      vram_valid_q    <= vram_valid_d;
      vram_address_q  <= vram_address_d;
      vram_write_q    <= vram_write_d;
      vram_wdata_q    <= vram_wdata_d;
      cpu_ready_q     <= cpu_ready_d;
      command_ready_q <= command_ready_d;
    end
  end

  vdp_vram_tag_fifo u_tag_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (tag_push),
    .push_tag (grant_owner),
    .pop      (tag_pop),
    .head_tag (head_tag),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign vram.vram_valid   = vram_valid_q;
  assign vram.vram_address = vram_address_q;
  assign vram.vram_write   = vram_write_q;
  assign vram.vram_wdata   = vram_wdata_q;
  assign cpu_ready         = cpu_ready_q;
  assign command_ready     = command_ready_q;

  // Read return is routed combinationally; rdata stays 0 when nothing is returned.
  assign screen_rdata_en  = tag_pop && (head_tag == OWNER_SCREEN);
  assign sprite_rdata_en  = tag_pop && (head_tag == OWNER_SPRITE);
  assign cpu_rdata_en     = tag_pop && (head_tag == OWNER_CPU);
  assign command_rdata_en = tag_pop && (head_tag == OWNER_COMMAND);
  assign rdata            = tag_pop ? vram.vram_rdata : '0;

endmodule

// File: tb/tb_vdp_vram_access_arbiter.sv
// tb/tb_vdp_vram_access_arbiter.sv - self-checking bench for vdp_vram_access_arbiter
module tb_vdp_vram_access_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [12:0] screen_pos_x;
  logic        screen_active, screen_valid, sprite_valid;
  logic [16:0] screen_address, sprite_address, cpu_address, command_address;
  logic        cpu_valid, cpu_write, command_valid, command_write;
  logic [7:0]  cpu_wdata, command_wdata;
  logic        screen_rdata_en, sprite_rdata_en, cpu_rdata_en, command_rdata_en;
  logic        cpu_ready, command_ready;
  logic [31:0] rdata;

  vdp_vram_access_arbiter_if vif ();

  vdp_vram_access_arbiter dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .screen_pos_x     (screen_pos_x),
    .screen_active    (screen_active),
    .screen_address   (screen_address),
    .screen_valid     (screen_valid),
    .screen_rdata_en  (screen_rdata_en),
    .sprite_address   (sprite_address),
    .sprite_valid     (sprite_valid),
    .sprite_rdata_en  (sprite_rdata_en),
    .cpu_address      (cpu_address),
    .cpu_valid        (cpu_valid),
    .cpu_write        (cpu_write),
    .cpu_wdata        (cpu_wdata),
    .cpu_ready        (cpu_ready),
    .cpu_rdata_en     (cpu_rdata_en),
    .command_address  (command_address),
    .command_valid    (command_valid),
    .command_write    (command_write),
    .command_wdata    (command_wdata),
    .command_ready    (command_ready),
    .command_rdata_en (command_rdata_en),
    .vram             (vif),
    .rdata            (rdata)
  );

  always #5 clk = ~clk;

`ifdef VDP_VRAM_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of outstanding read owners (0 screen, 1 sprite,
  // 2 cpu, 3 command) and the grant expected on the bus in the next cycle.
  int          tq[$];
  bit          e_valid, e_write, e_cpu_ready, e_cmd_ready, last_cpu;
  logic [16:0] e_addr;
  logic [7:0]  e_wdata;
  bit          m_pop;
  int          m_head, owner;

  always @(negedge clk) begin
    if (!reset_n) begin
      tq.delete();
      e_valid = 0; e_write = 0; e_cpu_ready = 0; e_cmd_ready = 0; last_cpu = 0;
      check("rst_vram_valid", vif.vram_valid, 0);
      check("rst_vram_address", vif.vram_address, 0);
      check("rst_vram_write", vif.vram_write, 0);
      check("rst_vram_wdata", vif.vram_wdata, 0);
      check("rst_readies", {cpu_ready, command_ready}, 0);
      check("rst_rdata_ens", {screen_rdata_en, sprite_rdata_en, cpu_rdata_en, command_rdata_en}, 0);
      check("rst_rdata", rdata, 0);
    end else begin
      m_pop  = vif.vram_rdata_en && (tq.size() > 0);
      m_head = m_pop ? tq[0] : -1;
      check("m_screen_rdata_en", screen_rdata_en, m_head == 0);
      check("m_sprite_rdata_en", sprite_rdata_en, m_head == 1);
      check("m_cpu_rdata_en", cpu_rdata_en, m_head == 2);
      check("m_command_rdata_en", command_rdata_en, m_head == 3);
      check("m_rdata", rdata, m_pop ? vif.vram_rdata : 32'h0);
      check("m_vram_valid", vif.vram_valid, e_valid);
      check("m_vram_write", vif.vram_write, e_write);
      check("m_cpu_ready", cpu_ready, e_cpu_ready);
      check("m_command_ready", command_ready, e_cmd_ready);
      if (e_valid) check("m_vram_address", vif.vram_address, e_addr);
      if (e_valid && e_write) check("m_vram_wdata", vif.vram_wdata, e_wdata);

      owner = -1;
      if ((screen_pos_x % 8 == 0) && (tq.size() < 4 || m_pop)) begin
        if (screen_valid && screen_active) owner = 0;
        else if (sprite_valid) owner = 1;
        else if (cpu_valid && command_valid) owner = (RR_EN && last_cpu) ? 3 : 2;
        else if (cpu_valid) owner = 2;
        else if (command_valid) owner = 3;
      end
      e_valid = (owner >= 0);
      e_write = 0; e_wdata = 0; e_addr = 0;
      case (owner)
        0: e_addr = screen_address;
        1: e_addr = sprite_address;
        2: begin e_addr = cpu_address; e_write = cpu_write; e_wdata = cpu_wdata; end
        3: begin e_addr = command_address; e_write = command_write; e_wdata = command_wdata; end
        default: ;
      endcase
      e_cpu_ready = (owner == 2);
      e_cmd_ready = (owner == 3);
      if (owner == 2) last_cpu = 1;
      if (owner == 3) last_cpu = 0;
      if (m_pop) void'(tq.pop_front());
      if (owner >= 0 && !e_write) tq.push_back(owner);
    end
  end

  task automatic tick(input logic [12:0] x);
    @(posedge clk);
    #1;
    screen_pos_x = x;
  endtask

  bit exp_c;

  initial begin
    reset_n = 0; screen_pos_x = 13'd1; screen_active = 0; screen_valid = 0; sprite_valid = 0;
    screen_address = 0; sprite_address = 0; cpu_address = 0; command_address = 0;
    cpu_valid = 0; cpu_write = 0; command_valid = 0; command_write = 0;
    cpu_wdata = 0; command_wdata = 0;
    vif.vram_rdata = 32'hFFFFFFFF; vif.vram_rdata_en = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rdata_zero", rdata, 32'h0);
    check("reset_valid_zero", vif.vram_valid, 0);

    for (int x = 5; x <= 124; x++) begin
      tick(13'(x));
      case (x)
        5:   begin reset_n = 1; vif.vram_rdata_en = 0; vif.vram_rdata = 0; end
        8:   begin screen_active = 1; screen_valid = 1; screen_address = 17'h01234;
                   cpu_valid = 1; cpu_write = 0; cpu_address = 17'h00777; end
        9:   screen_valid = 0;
        18:  begin cpu_valid = 0; vif.vram_rdata_en = 1; vif.vram_rdata = 32'hDEADBEEF; end
        19:  vif.vram_rdata = 32'h12345678;
        20:  vif.vram_rdata = 32'hCAFEF00D;
        21:  begin vif.vram_rdata_en = 0; screen_active = 0; screen_valid = 1; end
        24:  begin cpu_valid = 1; cpu_write = 1; cpu_address = 17'h1FFFF; cpu_wdata = 8'hA5; end
        26:  begin cpu_valid = 0; cpu_write = 0; end
        27:  vif.vram_rdata_en = 1;
        28:  begin vif.vram_rdata_en = 0; screen_valid = 0; end
        30:  reset_n = 0;
        31:  reset_n = 1;
        32:  begin cpu_valid = 1; cpu_address = 17'h00100; command_valid = 1;
                   command_write = 0; command_address = 17'h00200; end
        58:  begin cpu_valid = 0; command_valid = 0; vif.vram_rdata_en = 1; vif.vram_rdata = 32'h0BADF00D; end
        62:  vif.vram_rdata_en = 0;
        64:  begin sprite_valid = 1; sprite_address = 17'h0ABCD; end
        104: begin vif.vram_rdata_en = 1; vif.vram_rdata = 32'h55AA55AA; end
        105: begin vif.vram_rdata_en = 0; sprite_valid = 0; end
        106: vif.vram_rdata_en = 1;
        110: vif.vram_rdata_en = 0;
        112: sprite_valid = 1;
        121: sprite_valid = 0;
        122: begin reset_n = 0; vif.vram_rdata_en = 1; vif.vram_rdata = 32'hFFFFFFFF; end
        123: reset_n = 1;
        124: vif.vram_rdata_en = 0;
        default: ;
      endcase
      @(negedge clk);
      case (x)
        9:   begin check("screen_grant_valid", vif.vram_valid, 1);
                   check("screen_grant_addr", vif.vram_address, 17'h01234);
                   check("screen_grant_cpu_no_ready", cpu_ready, 0); end
        17:  begin check("cpu_read_ready", cpu_ready, 1);
                   check("cpu_read_addr", vif.vram_address, 17'h00777); end
        18:  begin check("ret1_screen_en", screen_rdata_en, 1);
                   check("ret1_cpu_en", cpu_rdata_en, 0);
                   check("ret1_rdata", rdata, 32'hDEADBEEF); end
        19:  begin check("ret2_cpu_en", cpu_rdata_en, 1);
                   check("ret2_screen_en", screen_rdata_en, 0);
                   check("ret2_rdata", rdata, 32'h12345678); end
        20:  begin check("empty_pop_en", {screen_rdata_en, cpu_rdata_en}, 0);
                   check("empty_pop_rdata", rdata, 32'h0); end
        25:  begin check("wr_valid", vif.vram_valid, 1);
                   check("wr_write", vif.vram_write, 1);
                   check("wr_wdata", vif.vram_wdata, 8'hA5);
                   check("wr_addr", vif.vram_address, 17'h1FFFF);
                   check("wr_ready", cpu_ready, 1); end
        26:  begin check("wr_single_valid", vif.vram_valid, 0);
                   check("wr_single_ready", cpu_ready, 0); end
        27:  check("wr_no_tag", cpu_rdata_en, 0);
        97:  check("sprite_fifo_full_block", vif.vram_valid, 0);
        104: begin check("sprite_pop_at_full", sprite_rdata_en, 1);
                   check("sprite_pop_rdata", rdata, 32'h55AA55AA); end
        105: begin check("sprite_push_at_full", vif.vram_valid, 1);
                   check("sprite_push_addr", vif.vram_address, 17'h0ABCD); end
        122: begin check("rst_mid_valid", vif.vram_valid, 0);
                   check("rst_mid_en", sprite_rdata_en, 0);
                   check("rst_mid_rdata", rdata, 32'h0); end
        123: begin check("rst_after_en", sprite_rdata_en, 0);
                   check("rst_after_rdata", rdata, 32'h0); end
        default: ;
      endcase
      if (x >= 33 && x <= 57 && (x % 8 == 1)) begin
        exp_c = RR_EN ? (((x - 33) / 8) % 2 == 0) : 1'b1;
        check("cpucmd_cpu_ready", cpu_ready, exp_c);
        check("cpucmd_cmd_ready", command_ready, !exp_c);
        check("cpucmd_addr", vif.vram_address, exp_c ? 17'h00100 : 17'h00200);
      end
      if (x >= 65 && x <= 89 && (x % 8 == 1)) check("sprite_fill_valid", vif.vram_valid, 1);
    end

    for (int n = 0; n < 4000; n++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 63) == 0) screen_pos_x = 13'($urandom);
      else screen_pos_x = screen_pos_x + 13'd1;
      reset_n = ($urandom_range(0, 499) != 0);
      screen_active = ($urandom_range(0, 3) != 0);
      screen_valid = ($urandom_range(0, 2) == 0);
      screen_address = 17'($urandom);
      sprite_valid = ($urandom_range(0, 2) == 0);
      sprite_address = 17'($urandom);
      if (!cpu_valid || cpu_ready) begin
        cpu_valid = ($urandom_range(0, 1) == 0);
        cpu_address = 17'($urandom); cpu_write = 1'($urandom); cpu_wdata = 8'($urandom);
      end
      if (!command_valid || command_ready) begin
        command_valid = ($urandom_range(0, 1) == 0);
        command_address = 17'($urandom); command_write = 1'($urandom); command_wdata = 8'($urandom);
      end
      vif.vram_rdata_en = ($urandom_range(0, 3) == 0);
      vif.vram_rdata = $urandom;
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
